gen_div: RTL and testbench

- Multi-cycle signed restoring divider; the inverse operation of the team's combinational generic multiplier.
- Divides a 2*DATA_WIDTH dividend (e.g. a multiplier product) by a DATA_WIDTH divisor. Returns a DATA_WIDTH quotient and remainder.
- Used in the datapath wherever a product must be normalised or scaled back down.
- start/busy/done handshake; fixed latency for every operand set.

---
 rtl/gen_div_if.sv | 22 ++
 rtl/gen_div.sv | 119 +++++++++++
 tb/tb_gen_div.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/gen_div_if.sv
// gen_div_if: start/busy/done handshake and operand/result bus for gen_div
interface gen_div_if #(parameter int DATA_WIDTH = 16) ();
    logic                    start;
    logic [2*DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0]   divisor;
    logic                    busy;
    logic                    done;
    logic [DATA_WIDTH-1:0]   quotient;
    logic [DATA_WIDTH-1:0]   remainder;
    logic                    overflow;
    logic                    div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, overflow, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/gen_div.sv
// gen_div: multi-cycle signed restoring divider, 2W-bit dividend by W-bit divisor, fixed latency.
// Define GEN_DIV_SAT_EN to saturate the quotient on overflow instead of wrapping it.
module gen_div #(
    parameter int DATA_WIDTH = 16
) (
    input logic     clk,
    input logic     rst_n,
    gen_div_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(2 * W);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  acc;
    logic [W:0]      rem;
    logic [W-1:0]    dvs;
    logic [W-1:0]    dvd_lo;
    logic            dneg, qneg, dz;
    logic [W+1:0]    sh, diff;
    logic            ge;
    logic [2*W:0]    q_s;
    logic            ovf;
    logic [W-1:0]    q_fix;
    logic            busy_q, done_q, ovf_q, dz_q;
    logic [W-1:0]    quot_q, rem_q;

    // Next-state logic: CALC runs exactly 2W iterations, FIX and DONE one cycle each
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = bus.start ? CALC : IDLE;
            CALC:    state_nxt = (cnt == CW'(2 * W - 1)) ? FIX : CALC;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step plus sign fix-up; the quotient is kept in 2W+1 bits so -2^(2W-1) never wraps
    always_comb begin
        sh    = {rem, acc[2*W-1]};
        diff  = sh - {2'b00, dvs};
        ge    = ~diff[W+1];
        q_s   = qneg ? -{1'b0, acc} : {1'b0, acc};
        ovf   = ~(&q_s[2*W:W-1] | ~|q_s[2*W:W-1]);
`ifdef GEN_DIV_SAT_EN
        q_fix = ovf ? (q_s[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : q_s[W-1:0];
`else
        q_fix = q_s[W-1:0];
`endif
    end

    // State register; busy/done are registered so done lands one cycle after the DONE state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= state_nxt != IDLE;
            done_q <= state == DONE;
        end
    end

    // Datapath: latch magnitudes on start, iterate in CALC, register signed results in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            rem    <= '0;
            dvs    <= '0;
            dvd_lo <= '0;
            dneg   <= 1'b0;
            qneg   <= 1'b0;
            dz     <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    acc    <= bus.dividend[2*W-1] ? -bus.dividend : bus.dividend;
                    dvs    <= bus.divisor[W-1] ? -bus.divisor : bus.divisor;
                    dvd_lo <= bus.dividend[W-1:0];
                    dneg   <= bus.dividend[2*W-1];
                    qneg   <= bus.dividend[2*W-1] ^ bus.divisor[W-1];
                    dz     <= bus.divisor == '0;
                    rem    <= '0;
                    cnt    <= '0;
                    ovf_q  <= 1'b0;
                    dz_q   <= 1'b0;
                end
                CALC: begin
                    rem <= ge ? diff[W:0] : sh[W:0];
                    acc <= {acc[2*W-2:0], ge};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    quot_q <= dz ? '1 : q_fix;
                    rem_q  <= dz ? dvd_lo : (dneg ? -rem[W-1:0] : rem[W-1:0]);
                    ovf_q  <= ~dz & ovf;
                    dz_q   <= dz;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_gen_div.sv
// tb_gen_div: directed self-checking bench for gen_div (DATA_WIDTH=16)
module tb_gen_div;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   lat, lat1, lat2;
    logic seen;

    gen_div_if #(.DATA_WIDTH(16)) bus ();
    gen_div #(.DATA_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

`ifdef GEN_DIV_SAT_EN
    localparam logic [15:0] Q_OVF_POS = 16'h7FFF;
    localparam logic [15:0] Q_MINNEG  = 16'h7FFF;
    localparam logic [15:0] Q_32768   = 16'h7FFF;
`else
    localparam logic [15:0] Q_OVF_POS = 16'h0000;
    localparam logic [15:0] Q_MINNEG  = 16'h0000;
    localparam logic [15:0] Q_32768   = 16'h8000;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [15:0] b, input int inj, output int l);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = 16'($urandom);
        chk("busy_after_start", bus.busy, 1);
        chk("flags_clear_on_start", {bus.overflow, bus.div_by_zero}, 0);
        l = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == inj) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd7;
                bus.divisor  = 16'd3;
            end
            @(posedge clk);
            #1;
            if (k == inj) bus.start = 1'b0;
            if (bus.done) begin
                l = k;
                break;
            end
        end
        chk("latency", l, 34);
        chk("busy_low_at_done", bus.busy, 0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", bus.done, 0);
    endtask

    task automatic res(input string tag, input logic [15:0] q, input logic [15:0] r, input logic ov, input logic z);
        chk({tag, "_quotient"}, bus.quotient, q);
        chk({tag, "_remainder"}, bus.remainder, r);
        chk({tag, "_flags"}, {bus.overflow, bus.div_by_zero}, {ov, z});
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #12;
        chk("reset_state", {bus.busy, bus.done, bus.overflow, bus.div_by_zero, bus.quotient, bus.remainder}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(32'd600, 16'd7, 0, lat);
        res("pos_pos", 16'd85, 16'd5, 0, 0);
        run(32'hFFFFFDA8, 16'd7, 0, lat);
        res("neg_pos", 16'hFFAB, 16'hFFFB, 0, 0);
        run(32'hFFFF6FDC, 16'd123, 0, lat);
        res("product_div_123", 16'hFED4, 16'h0000, 0, 0);
        run(32'hFFFF6FDC, 16'hFED4, 0, lat);
        res("product_div_m300", 16'd123, 16'h0000, 0, 0);
        run(32'h00010000, 16'd1, 0, lat);
        res("overflow_pos", Q_OVF_POS, 16'h0000, 1, 0);
        run(32'h80000000, 16'hFFFF, 0, lat);
        res("most_neg_div_m1", Q_MINNEG, 16'h0000, 1, 0);
        run(32'hC0000000, 16'h8000, 0, lat);
        res("q_plus_32768", Q_32768, 16'h0000, 1, 0);
        run(32'h40000000, 16'h8000, 0, lat);
        res("q_minus_32768", 16'h8000, 16'h0000, 0, 0);
        run(32'h00001234, 16'd0, 0, lat);
        res("div_by_zero", 16'hFFFF, 16'h1234, 0, 1);
        run(32'd1000, 16'd10, 5, lat);
        res("start_while_busy", 16'd100, 16'h0000, 0, 0);

        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd600;
        bus.divisor  = 16'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_op", {bus.busy, bus.done, bus.overflow, bus.div_by_zero, bus.quotient, bus.remainder}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (45) begin
            @(posedge clk);
            #1;
            seen |= bus.done;
        end
        chk("no_done_after_reset", seen, 0);

        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd600;
        bus.divisor  = 16'd7;
        @(posedge clk);
        lat1 = 0;
        lat2 = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (bus.done && lat1 == 0) lat1 = k;
            else if (bus.done && lat2 == 0) lat2 = k;
        end
        bus.start = 1'b0;
        chk("back_to_back_first", lat1, 34);
        chk("back_to_back_second", lat2, 69);
        res("back_to_back", 16'd85, 16'd5, 0, 0);
        repeat (40) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
